// File: rtl/cdnsusbhs_sync_evt_arb_pkg.sv
// ---------------------------------------------------------------------------
// cdnsusbhs_sync_evt_arb_pkg
//   Shared definitions for the rxclk-domain synchronizer event scheduler:
//   the FSM state encoding, the legal ranges of NUM_SRC and FILT_CYC, and
//   the width of the glitch-filter counter.
// ---------------------------------------------------------------------------
package cdnsusbhs_sync_evt_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } evt_state_e;

  localparam int NUM_SRC_MIN  = 2;
  localparam int NUM_SRC_MAX  = 16;
  localparam int FILT_CYC_MIN = 1;
  localparam int FILT_CYC_MAX = 15;
  // Wide enough to hold FILT_CYC_MAX
  localparam int FILT_CNT_W   = 4;

endpackage

// File: rtl/cdnsusbhs_sync_evt_filt.sv
// ---------------------------------------------------------------------------
// cdnsusbhs_sync_evt_filt
//   Per-source glitch filter. Counts consecutive cycles on which the
//   synchronized input differs from the last accepted level and qualifies
//   the change once it has been seen for FILT_CYC cycles. Only instantiated
//   when CDNSUSBHS_SYNC_EVT_FILTER_EN is defined.
// Ports
//   rxclk   in  clock, rising edge
//   rxrst   in  synchronous active-high reset
//   i_diff  in  input level differs from accepted level this cycle
//   o_qual  out difference has persisted long enough to count as a change
// ---------------------------------------------------------------------------
module cdnsusbhs_sync_evt_filt
  import cdnsusbhs_sync_evt_arb_pkg::*;
#(
  parameter int FILT_CYC = 3
) (
  input  logic rxclk,
  input  logic rxrst,
  input  logic i_diff,
  output logic o_qual
);

  localparam logic [FILT_CNT_W-1:0] CNT_MAX = FILT_CNT_W'(FILT_CYC);

  logic [FILT_CNT_W-1:0] r_cnt;

  // Counter saturates at FILT_CYC; any matching cycle restarts the count
  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      r_cnt <= '0;
    end else if (!i_diff) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_qual = i_diff && (r_cnt == CNT_MAX);

endmodule

// File: rtl/cdnsusbhs_sync_evt_arb.sv
// ---------------------------------------------------------------------------
// cdnsusbhs_sync_evt_arb
//   Scheduler for the rxclk-domain outputs of NUM_SRC bit synchronizers.
//   Level changes are latched as pending events, round-robin arbitrated onto
//   a single valid/ready event port, and a change arriving while the source
//   still has an event pending sets a sticky overflow bit.
//   Optional build macro: CDNSUSBHS_SYNC_EVT_FILTER_EN inserts a FILT_CYC
//   glitch filter per source ahead of edge detection.
// Ports
//   rxclk      in   clock, rising edge
//   rxrst      in   synchronous active-high reset
//   sync_in    in   synchronized levels
//   src_en     in   per-source event enable
//   evt_valid  out  event offered
//   evt_ready  in   consumer accepts the event
//   evt_src    out  source index of offered event
//   evt_level  out  new level of that source
//   pend       out  pending-event bits
//   evt_ovf    out  sticky per-source overflow
//   ovf_clr    in   write-1-to-clear for evt_ovf
// ---------------------------------------------------------------------------
module cdnsusbhs_sync_evt_arb
  import cdnsusbhs_sync_evt_arb_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int IDX_W    = 2,
  parameter int FILT_CYC = 3
) (
  input  logic               rxclk,
  input  logic               rxrst,
  input  logic [NUM_SRC-1:0] sync_in,
  input  logic [NUM_SRC-1:0] src_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [IDX_W-1:0]   evt_src,
  output logic               evt_level,
  output logic [NUM_SRC-1:0] pend,
  output logic [NUM_SRC-1:0] evt_ovf,
  input  logic [NUM_SRC-1:0] ovf_clr
);

  evt_state_e         r_state, w_state_nxt;
  logic [NUM_SRC-1:0] r_lvl, r_pend, r_pend_lvl, r_ovf;
  logic [NUM_SRC-1:0] w_diff, w_chg, w_elig, w_gnt;
  logic [IDX_W-1:0]   r_rr_ptr, r_src, w_win;
  logic               r_evt_lvl, w_any, w_load;

  assign w_diff = sync_in ^ r_lvl;

`ifdef CDNSUSBHS_SYNC_EVT_FILTER_EN
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_filt
    cdnsusbhs_sync_evt_filt #(
      .FILT_CYC (FILT_CYC)
    ) u_filt (
      .rxclk  (rxclk),
      .rxrst  (rxrst),
      .i_diff (w_diff[g]),
      .o_qual (w_chg[g])
    );
  end
`else
  // FILT_CYC has no effect without the filter
  logic w_unused_filt_cyc;
  assign w_unused_filt_cyc = (FILT_CYC > 0);
  assign w_chg = w_diff;
`endif

  assign w_elig = r_pend & src_en;

  // Round-robin: scan from the highest offset down so the source closest
  // to r_rr_ptr is the last (and winning) assignment
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int off = NUM_SRC - 1; off >= 0; off--) begin
      if (w_elig[(int'(r_rr_ptr) + off) % NUM_SRC]) begin
        w_any = 1'b1;
        w_win = IDX_W'((int'(r_rr_ptr) + off) % NUM_SRC);
      end
    end
  end

  // FSM next state; w_load marks the cycle a winner is moved to the port
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_load      = 1'b1;
          w_state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (evt_ready) begin
          if (w_any) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt = '0;
    if (w_load) begin
      w_gnt[w_win] = 1'b1;
    end
  end

  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      r_src     <= '0;
      r_evt_lvl <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (w_load) begin
      r_src     <= w_win;
      r_evt_lvl <= r_pend_lvl[w_win];
      r_rr_ptr  <= (int'(w_win) == NUM_SRC - 1) ? '0 : w_win + 1'b1;
    end
  end

  // A new change beats a same-cycle grant clear, and an overflow set beats
  // a same-cycle ovf_clr
  always_ff @(posedge rxclk) begin
    if (rxrst) begin
      r_lvl      <= '1;
      r_pend     <= '0;
      r_pend_lvl <= '0;
      r_ovf      <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_chg[i]) begin
          r_lvl[i] <= sync_in[i];
        end
        if (!src_en[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_chg[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_gnt[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (w_chg[i] && src_en[i]) begin
          r_pend_lvl[i] <= sync_in[i];
        end
        if (w_chg[i] && r_pend[i] && !w_gnt[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (ovf_clr[i]) begin
          r_ovf[i] <= 1'b0;
        end
      end
    end
  end

  assign evt_valid = (r_state == ST_OFFER);
  assign evt_src   = r_src;
  assign evt_level = r_evt_lvl;
  assign pend      = r_pend;
  assign evt_ovf   = r_ovf;

endmodule

// File: tb/tb_cdnsusbhs_sync_evt_arb.sv
// ---------------------------------------------------------------------------
// tb_cdnsusbhs_sync_evt_arb
//   Directed bench for cdnsusbhs_sync_evt_arb (NUM_SRC=4). A table of
//   per-cycle vectors covers single events, back-to-back bursts, round-robin
//   order and back-pressure; hand-written sequences cover overflow, enable
//   masking, reset while offering and, with CDNSUSBHS_SYNC_EVT_FILTER_EN,
//   the glitch filter.
// ---------------------------------------------------------------------------
module tb_cdnsusbhs_sync_evt_arb;

  logic       rxclk = 1'b0;
  logic       rxrst;
  logic [3:0] sync_in, src_en, ovf_clr, pend, evt_ovf;
  logic       evt_valid, evt_ready, evt_level;
  logic [1:0] evt_src;

  int n_checks = 0;
  int n_errors = 0;

  always #5 rxclk = ~rxclk;

  cdnsusbhs_sync_evt_arb #(
    .NUM_SRC  (4),
    .IDX_W    (2),
    .FILT_CYC (3)
  ) dut (
    .rxclk     (rxclk),
    .rxrst     (rxrst),
    .sync_in   (sync_in),
    .src_en    (src_en),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_src   (evt_src),
    .evt_level (evt_level),
    .pend      (pend),
    .evt_ovf   (evt_ovf),
    .ovf_clr   (ovf_clr)
  );

  typedef struct {
    logic       rst;
    logic [3:0] sync;
    logic [3:0] en;
    logic       rdy;
    logic [3:0] clr;
    logic       vld;
    logic [1:0] src;
    logic       lvl;
    logic [3:0] pnd;
    logic [3:0] ovf;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_offer(input string name, input logic [1:0] src, input logic lvl);
    check({name, ".valid"}, 32'(evt_valid), 32'd1);
    check({name, ".src"},   32'(evt_src),   32'(src));
    check({name, ".level"}, 32'(evt_level), 32'(lvl));
  endtask

  initial begin
    rxrst = 1'b1; sync_in = 4'hF; src_en = 4'hF; evt_ready = 1'b1; ovf_clr = 4'h0;

    // Reset state and quiet release
    tick();
    check("rst.valid", 32'(evt_valid), 32'd0);
    check("rst.src",   32'(evt_src),   32'd0);
    check("rst.level", 32'(evt_level), 32'd0);
    check("rst.pend",  32'(pend),      32'd0);
    check("rst.ovf",   32'(evt_ovf),   32'd0);
    rxrst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check("quiet.valid", 32'(evt_valid), 32'd0);
      check("quiet.pend",  32'(pend),      32'd0);
    end

    //           rst  sync  en    rdy clr   vld src lvl pnd   ovf
    // single fall on src 2: pend after 1 edge, offered for one cycle
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 0, 0, 0, 4'h4, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 1, 2, 0, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    tbl.push_back('{1, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    // all four fall together: back-to-back 0,1,2,3
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'hF, 4'h0});
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 1, 0, 0, 4'hE, 4'h0});
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 1, 1, 0, 4'hC, 4'h0});
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 1, 2, 0, 4'h8, 4'h0});
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 1, 3, 0, 4'h0, 4'h0});
    tbl.push_back('{0, 4'h0, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    // rise on 1 moves pointer to 2, then 0 and 3 together: 3 wins first
    tbl.push_back('{0, 4'h2, 4'hF, 1, 4'h0, 0, 0, 0, 4'h2, 4'h0});
    tbl.push_back('{0, 4'h2, 4'hF, 1, 4'h0, 1, 1, 1, 4'h0, 4'h0});
    tbl.push_back('{0, 4'h2, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 0, 0, 0, 4'h9, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 1, 3, 1, 4'h1, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 1, 0, 1, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hB, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});
    // rise on 2 under back-pressure: offer holds until ready
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 0, 0, 0, 4'h4, 4'h0});
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hF, 4'hF, 0, 4'h0, 1, 2, 1, 4'h0, 4'h0});
    tbl.push_back('{0, 4'hF, 4'hF, 1, 4'h0, 0, 0, 0, 4'h0, 4'h0});

    for (int r = 0; r < tbl.size(); r++) begin
      rxrst = tbl[r].rst; sync_in = tbl[r].sync; src_en = tbl[r].en;
      evt_ready = tbl[r].rdy; ovf_clr = tbl[r].clr;
      tick();
      check($sformatf("row%0d.valid", r), 32'(evt_valid), 32'(tbl[r].vld));
      if (tbl[r].vld) begin
        check($sformatf("row%0d.src", r),   32'(evt_src),   32'(tbl[r].src));
        check($sformatf("row%0d.level", r), 32'(evt_level), 32'(tbl[r].lvl));
      end
      check($sformatf("row%0d.pend", r), 32'(pend),    32'(tbl[r].pnd));
      check($sformatf("row%0d.ovf", r),  32'(evt_ovf), 32'(tbl[r].ovf));
    end
    rxrst = 1'b0;

    // Overflow: src 0 stalls the port while src 1 toggles twice
    evt_ready = 1'b0;
    sync_in = 4'hE; tick();
    tick();
    check_offer("ovf.blk", 2'd0, 1'b0);
    sync_in = 4'hC; tick();
    check("ovf.pend1", 32'(pend), 32'h2);
    check("ovf.none",  32'(evt_ovf), 32'h0);
    sync_in = 4'hE; tick();
    check("ovf.set",   32'(evt_ovf), 32'h2);
    check_offer("ovf.hold", 2'd0, 1'b0);
    evt_ready = 1'b1; tick();
    check_offer("ovf.src1", 2'd1, 1'b1);
    check("ovf.pend0", 32'(pend), 32'h0);
    tick();
    check("ovf.single", 32'(evt_valid), 32'd0);
    check("ovf.sticky", 32'(evt_ovf), 32'h2);
    ovf_clr = 4'h2; tick();
    ovf_clr = 4'h0;
    check("ovf.clr", 32'(evt_ovf), 32'h0);

    // Disabled source produces nothing in either direction
    src_en = 4'hE;
    sync_in = 4'hF;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("dis.rise.valid", 32'(evt_valid), 32'd0);
      check("dis.rise.pend",  32'(pend), 32'h0);
    end
    sync_in = 4'hE;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("dis.fall.valid", 32'(evt_valid), 32'd0);
      check("dis.fall.pend",  32'(pend), 32'h0);
    end

    // Reset while offering, with a pending event and overflow present
    src_en = 4'hF; evt_ready = 1'b0;
    sync_in = 4'hC; tick();
    tick();
    check_offer("rsto.offer", 2'd1, 1'b0);
    sync_in = 4'h4; tick();
    sync_in = 4'hC; tick();
    check("rsto.ovf", 32'(evt_ovf), 32'h8);
    check("rsto.pend", 32'(pend), 32'h8);
    rxrst = 1'b1; sync_in = 4'hF; tick();
    check("rsto.valid", 32'(evt_valid), 32'd0);
    check("rsto.pend0", 32'(pend), 32'h0);
    check("rsto.ovf0",  32'(evt_ovf), 32'h0);
    rxrst = 1'b0; evt_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rsto.quiet", 32'(evt_valid), 32'd0);
    end

`ifdef CDNSUSBHS_SYNC_EVT_FILTER_EN
    // 2-cycle glitch on src 3 is filtered out
    sync_in = 4'h7; tick();
    tick();
    sync_in = 4'hF;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("filt.glitch.valid", 32'(evt_valid), 32'd0);
      check("filt.glitch.pend",  32'(pend), 32'h0);
    end
    // Stable fall: offered 5 edges after the change
    sync_in = 4'h7;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("filt.early%0d", c), 32'(evt_valid), 32'd0);
    end
    tick();
    check_offer("filt.evt", 2'd3, 1'b0);
    tick();
    check("filt.done", 32'(evt_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
